// File: rtl/gic_reg_pkg.sv
// Shared register-map constants and types for the interrupt controller responder.
package gic_reg_pkg;

  // Byte addresses of the word registers
  localparam logic [7:0] CTRL_A    = 8'h00;
  localparam logic [7:0] ENABLE_A  = 8'h04;
  localparam logic [7:0] PENDING_A = 8'h08;
  localparam logic [7:0] SETPEND_A = 8'h0C;
  localparam logic [7:0] CLAIM_A   = 8'h10;
  localparam logic [7:0] ACTIVE_A  = 8'h14;
  localparam logic [7:0] PRIO0_A   = 8'h20;
  localparam logic [7:0] PRIO1_A   = 8'h24;
  localparam logic [7:0] PRIO2_A   = 8'h28;
  localparam logic [7:0] PRIO3_A   = 8'h2C;
  localparam logic [7:0] ID_A      = 8'h3C;

  localparam logic [31:0] ID_VALUE = 32'h4749_4301;

  // Priority fields occupy 4-bit slots, eight per PRIO word
  localparam int unsigned PRIO_SLOT_W = 4;

  typedef logic [PRIO_SLOT_W-1:0] prio_t;

endpackage

// File: rtl/gic_prio_arbiter.sv
// Combinational max-priority selector; ties resolve to the lowest source index.
module gic_prio_arbiter #(
  parameter int unsigned NUM_IRQ = 32,
  parameter int unsigned PRIO_W  = 4
) (
  input  logic [NUM_IRQ-1:0]        elig,
  input  logic [NUM_IRQ*PRIO_W-1:0] prio,
  output logic [5:0]                id,
  output logic                      valid
);

  logic [PRIO_W-1:0] best;

  // Scan upward, replacing only on strictly greater priority so the lowest index keeps ties
  always_comb begin
    id    = '0;
    valid = 1'b0;
    best  = '0;
    for (int unsigned i = 0; i < NUM_IRQ; i++) begin
      if (elig[i] && (!valid || (prio[i*PRIO_W +: PRIO_W] > best))) begin
        valid = 1'b1;
        best  = prio[i*PRIO_W +: PRIO_W];
        id    = 6'(i);
      end
    end
  end

endmodule

// File: rtl/gic_reg_responder.sv
// Register-bus target for the interrupt controller: register bank, edge capture,
// claim/complete handshake and registered arbitration result.
module gic_reg_responder
  import gic_reg_pkg::*;
#(
  parameter int unsigned NUM_IRQ = 32,
  parameter int unsigned PRIO_W  = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [7:0]         addr,
  input  logic               wr_en,
  input  logic               rd_en,
  input  logic [31:0]        wdata,
  output logic [31:0]        rdata,
  input  logic [NUM_IRQ-1:0] irq_src,
  output logic               irq_out,
  output logic [5:0]         irq_id
);

  logic                      ctrl_en;
  logic [NUM_IRQ-1:0]        enable;
  logic [NUM_IRQ-1:0]        pending;
  logic [NUM_IRQ-1:0]        active;
  logic [NUM_IRQ*PRIO_W-1:0] prio_flat;
  logic [NUM_IRQ-1:0]        src_q;
  logic                      hist_vld;
  logic                      stale;
  logic [5:0]                best_id;
  logic                      best_valid;

  logic [7:0]                wa;
  logic [NUM_IRQ-1:0]        wmask;
  logic                      claim_ok;
  logic [NUM_IRQ-1:0]        claim_m;
  logic [NUM_IRQ-1:0]        eoi_m;
  logic [NUM_IRQ-1:0]        set_m;
  logic [NUM_IRQ-1:0]        clr_m;
  logic [NUM_IRQ-1:0]        pending_nx;
  logic [NUM_IRQ-1:0]        active_nx;
  logic [NUM_IRQ*PRIO_W-1:0] prio_nx;
  logic [NUM_IRQ-1:0]        prio_nz;
  logic [NUM_IRQ-1:0]        elig;
  logic [31:0]               rd_val;
  logic [5:0]                arb_id;
  logic                      arb_valid;
  logic                      unused_addr_bits;

  assign wa               = {addr[7:2], 2'b00};
  assign wmask            = wdata[NUM_IRQ-1:0];
  assign unused_addr_bits = ^addr[1:0];

  // A claim needs a fresh arbiter result and loses to a simultaneous write
  assign claim_ok = rd_en && !wr_en && (wa == CLAIM_A) && best_valid && !stale;

  // Per-source masks for claim, completion, pend set and pend clear
  always_comb begin
    claim_m = '0;
    eoi_m   = '0;
    prio_nz = '0;
    for (int unsigned i = 0; i < NUM_IRQ; i++) begin
      if (claim_ok && (best_id == 6'(i)))
        claim_m[i] = 1'b1;
      if (wr_en && (wa == CLAIM_A) && (wdata[5:0] == 6'(i + 1)))
        eoi_m[i] = 1'b1;
      prio_nz[i] = |prio_flat[i*PRIO_W +: PRIO_W];
    end
    set_m = (wr_en && (wa == SETPEND_A)) ? wmask : '0;
    // History is not trusted on the first cycle after reset, so a held-high source does not pend
    if (hist_vld)
      set_m = set_m | (irq_src & ~src_q);
    clr_m = ((wr_en && (wa == PENDING_A)) ? wmask : '0) | claim_m;
    // Set is applied after clear so it wins a same-cycle collision
    pending_nx = (pending & ~clr_m) | set_m;
    active_nx  = (active & ~eoi_m) | claim_m;
  end

  // Priority field writes: source n lives in word n/8, slot n%8
  always_comb begin
    prio_nx = prio_flat;
    for (int unsigned n = 0; n < NUM_IRQ; n++) begin
      if (wr_en && (wa == 8'(PRIO0_A + 4 * (n / 8))))
        prio_nx[n*PRIO_W +: PRIO_W] = wdata[4*(n%8) +: PRIO_W];
    end
  end

  // Read mux; reflects pre-write state, CLAIM returns a value only on a successful claim
  always_comb begin
    rd_val = '0;
    case (wa)
      CTRL_A:    rd_val[0]           = ctrl_en;
      ENABLE_A:  rd_val[NUM_IRQ-1:0] = enable;
      PENDING_A: rd_val[NUM_IRQ-1:0] = pending;
      ACTIVE_A:  rd_val[NUM_IRQ-1:0] = active;
      CLAIM_A:   if (claim_ok) rd_val[5:0] = best_id + 6'd1;
      ID_A:      rd_val              = ID_VALUE;
      default:   rd_val              = '0;
    endcase
    for (int unsigned n = 0; n < NUM_IRQ; n++) begin
      if (wa == 8'(PRIO0_A + 4 * (n / 8)))
        rd_val[4*(n%8) +: PRIO_W] = prio_flat[n*PRIO_W +: PRIO_W];
    end
  end

  assign elig = pending & enable & ~active & prio_nz;

  gic_prio_arbiter #(
    .NUM_IRQ (NUM_IRQ),
    .PRIO_W  (PRIO_W)
  ) u_arb (
    .elig  (elig),
    .prio  (prio_flat),
    .id    (arb_id),
    .valid (arb_valid)
  );

  // Register bank, edge history, stale flag, arbiter result and read data
  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl_en    <= 1'b0;
      enable     <= '0;
      pending    <= '0;
      active     <= '0;
      prio_flat  <= '0;
      src_q      <= '0;
      hist_vld   <= 1'b0;
      stale      <= 1'b0;
      best_id    <= '0;
      best_valid <= 1'b0;
      rdata      <= '0;
    end else begin
      if (wr_en && (wa == CTRL_A))
        ctrl_en <= wdata[0];
      if (wr_en && (wa == ENABLE_A))
        enable <= wmask;
      pending    <= pending_nx;
      active     <= active_nx;
      prio_flat  <= prio_nx;
      src_q      <= irq_src;
      hist_vld   <= 1'b1;
      stale      <= wr_en | claim_ok;
      best_id    <= arb_id;
      best_valid <= arb_valid;
      if (rd_en)
        rdata <= rd_val;
    end
  end

  assign irq_out = best_valid & ctrl_en;
  assign irq_id  = best_valid ? (best_id + 6'd1) : '0;

endmodule

// File: tb/tb_gic_reg_responder.sv
// Scenario bench for gic_reg_responder: read expectations queued at issue, checked on return.
module tb_gic_reg_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  addr;
  logic        wr_en;
  logic        rd_en;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic [31:0] irq_src;
  logic        irq_out;
  logic [5:0]  irq_id;

  int tests = 0;
  int fails = 0;
  logic [31:0] exp_q[$];

  gic_reg_responder #(.NUM_IRQ(32), .PRIO_W(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .addr    (addr),
    .wr_en   (wr_en),
    .rd_en   (rd_en),
    .wdata   (wdata),
    .rdata   (rdata),
    .irq_src (irq_src),
    .irq_out (irq_out),
    .irq_id  (irq_id)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // All tasks start and end 1 time unit after a rising edge
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    addr = a; wdata = d; wr_en = 1'b1;
    @(posedge clk); #1;
    wr_en = 1'b0;
  endtask

  task automatic rd(input logic [7:0] a, output logic [31:0] d);
    addr = a; rd_en = 1'b1;
    @(posedge clk); #1;
    rd_en = 1'b0;
    d = rdata;
  endtask

  task automatic test_reset();
    logic [31:0] got, e;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    tests++; if (rdata !== 32'h0) begin fails++; $display("FAIL reset_rdata: got %h exp 0", rdata); end
    tests++; if (irq_out !== 1'b0) begin fails++; $display("FAIL reset_irq_out: got %b exp 0", irq_out); end
    tests++; if (irq_id !== 6'd0) begin fails++; $display("FAIL reset_irq_id: got %0d exp 0", irq_id); end
    exp_q.push_back(32'h4749_4301);
    rd(8'h3C, got); e = exp_q.pop_front();
    tests++; if (got !== e) begin fails++; $display("FAIL id_reg: got %h exp %h", got, e); end
  endtask

  task automatic test_basic_claim();
    logic [31:0] got, e;
    wr(8'h04, 32'h8);
    wr(8'h20, 32'h0000_5000);
    wr(8'h00, 32'h1);
    irq_src[3] = 1'b1;
    tick();
    tests++; if (irq_out !== 1'b0) begin fails++; $display("FAIL irq_latency_early: got %b exp 0", irq_out); end
    irq_src[3] = 1'b0;
    tick();
    tests++; if (irq_out !== 1'b1) begin fails++; $display("FAIL irq_asserted: got %b exp 1", irq_out); end
    tests++; if (irq_id !== 6'd4) begin fails++; $display("FAIL irq_id_src3: got %0d exp 4", irq_id); end
    exp_q.push_back(32'd4);
    rd(8'h10, got); e = exp_q.pop_front();
    tests++; if (got !== e) begin fails++; $display("FAIL claim_src3: got %h exp %h", got, e); end
    exp_q.push_back(32'h8);
    rd(8'h14, got); e = exp_q.pop_front();
    tests++; if (got !== e) begin fails++; $display("FAIL active_after_claim: got %h exp %h", got, e); end
    tests++; if (irq_out !== 1'b0) begin fails++; $display("FAIL irq_drop_after_claim: got %b exp 0", irq_out); end
    exp_q.push_back(32'h0);
    rd(8'h08, got); e = exp_q.pop_front();
    tests++; if (got !== e) begin fails++; $display("FAIL pending_after_claim: got %h exp %h", got, e); end
    wr(8'h10, 32'd4);
    exp_q.push_back(32'h0);
    rd(8'h14, got); e = exp_q.pop_front();
    tests++; if (got !== e) begin fails++; $display("FAIL active_after_eoi: got %h exp %h", got, e); end
  endtask

  task automatic test_priority();
    logic [31:0] got, e;
    wr(8'h04, 32'h24);
    wr(8'h20, 32'h0070_0300);
    wr(8'h0C, 32'h24);
    tick();
    tests++; if (irq_id !== 6'd6) begin fails++; $display("FAIL irq_id_highprio: got %0d exp 6", irq_id); end
    exp_q.push_back(32'd6);
    exp_q.push_back(32'd0);
    exp_q.push_back(32'd3);
    for (int i = 0; i < 3; i++) begin
      rd(8'h10, got); e = exp_q.pop_front();
      tests++; if (got !== e) begin fails++; $display("FAIL back_to_back_claim%0d: got %h exp %h", i, got, e); end
    end
    wr(8'h10, 32'd6);
    wr(8'h10, 32'd3);
    exp_q.push_back(32'h0);
    rd(8'h14, got); e = exp_q.pop_front();
    tests++; if (got !== e) begin fails++; $display("FAIL active_after_two_eoi: got %h exp %h", got, e); end
    wr(8'h20, 32'h0030_0300);
    wr(8'h0C, 32'h24);
    tick();
    exp_q.push_back(32'd3);
    rd(8'h10, got); e = exp_q.pop_front();
    tests++; if (got !== e) begin fails++; $display("FAIL tie_lowest_index: got %h exp %h", got, e); end
    tick();
    exp_q.push_back(32'd6);
    rd(8'h10, got); e = exp_q.pop_front();
    tests++; if (got !== e) begin fails++; $display("FAIL tie_second_claim: got %h exp %h", got, e); end
    wr(8'h10, 32'd3);
    wr(8'h10, 32'd6);
    wr(8'h10, 32'd0);
    exp_q.push_back(32'h0);
    rd(8'h14, got); e = exp_q.pop_front();
    tests++; if (got !== e) begin fails++; $display("FAIL active_after_tie_eoi: got %h exp %h", got, e); end
  endtask

  task automatic test_set_clr_collision();
    logic [31:0] got, e;
    wr(8'h04, 32'h0);
    wr(8'h0C, 32'h1);
    addr = 8'h08; wdata = 32'h1; wr_en = 1'b1; irq_src[0] = 1'b1;
    @(posedge clk); #1;
    wr_en = 1'b0;
    exp_q.push_back(32'h1);
    rd(8'h08, got); e = exp_q.pop_front();
    tests++; if (got !== e) begin fails++; $display("FAIL set_beats_clear: got %h exp %h", got, e); end
    wr(8'h08, 32'h1);
    exp_q.push_back(32'h0);
    rd(8'h08, got); e = exp_q.pop_front();
    tests++; if (got !== e) begin fails++; $display("FAIL w1c_held_source: got %h exp %h", got, e); end
    irq_src[0] = 1'b0;
    exp_q.push_back(32'h0);
    rd(8'h40, got); e = exp_q.pop_front();
    tests++; if (got !== e) begin fails++; $display("FAIL unmapped_read: got %h exp %h", got, e); end
    exp_q.push_back(32'h0);
    rd(8'h0C, got); e = exp_q.pop_front();
    tests++; if (got !== e) begin fails++; $display("FAIL setpend_reads_zero: got %h exp %h", got, e); end
    exp_q.push_back(32'h0030_0300);
    rd(8'h20, got); e = exp_q.pop_front();
    tests++; if (got !== e) begin fails++; $display("FAIL prio0_readback: got %h exp %h", got, e); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] got, e;
    wr(8'h04, 32'h2);
    wr(8'h20, 32'h20);
    wr(8'h00, 32'h1);
    irq_src[1] = 1'b1;
    repeat (3) tick();
    exp_q.push_back(32'd2);
    rd(8'h10, got); e = exp_q.pop_front();
    tests++; if (got !== e) begin fails++; $display("FAIL claim_before_reset: got %h exp %h", got, e); end
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    tests++; if (rdata !== 32'h0) begin fails++; $display("FAIL midreset_rdata: got %h exp 0", rdata); end
    tests++; if (irq_out !== 1'b0) begin fails++; $display("FAIL midreset_irq_out: got %b exp 0", irq_out); end
    tests++; if (irq_id !== 6'd0) begin fails++; $display("FAIL midreset_irq_id: got %0d exp 0", irq_id); end
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h0);
    rd(8'h14, got); e = exp_q.pop_front();
    tests++; if (got !== e) begin fails++; $display("FAIL midreset_active: got %h exp %h", got, e); end
    rd(8'h08, got); e = exp_q.pop_front();
    tests++; if (got !== e) begin fails++; $display("FAIL midreset_pending: got %h exp %h", got, e); end
    rd(8'h04, got); e = exp_q.pop_front();
    tests++; if (got !== e) begin fails++; $display("FAIL midreset_enable: got %h exp %h", got, e); end
    rd(8'h00, got); e = exp_q.pop_front();
    tests++; if (got !== e) begin fails++; $display("FAIL midreset_ctrl: got %h exp %h", got, e); end
    repeat (3) tick();
    exp_q.push_back(32'h0);
    rd(8'h08, got); e = exp_q.pop_front();
    tests++; if (got !== e) begin fails++; $display("FAIL held_source_no_repend: got %h exp %h", got, e); end
    irq_src[1] = 1'b0;
    tick();
    irq_src[1] = 1'b1;
    tick();
    exp_q.push_back(32'h2);
    rd(8'h08, got); e = exp_q.pop_front();
    tests++; if (got !== e) begin fails++; $display("FAIL repend_after_new_edge: got %h exp %h", got, e); end
    irq_src[1] = 1'b0;
  endtask

  initial begin
    rst = 1'b1; addr = '0; wr_en = 1'b0; rd_en = 1'b0; wdata = '0; irq_src = '0;
    test_reset();
    test_basic_claim();
    test_priority();
    test_set_clr_collision();
    test_reset_mid();
    if (exp_q.size() != 0) begin
      tests++; fails++;
      $display("FAIL scoreboard_drain: got %0d left exp 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/gic_reg_responder.md
# gic_reg_responder

Register-bus responder for the interrupt controller: the target end of the 8-bit-address / 32-bit-data register bus (addr, wr_en, rd_en, wdata, rdata) that the bench driver and the CPU-side initiator drive. It holds the controller's programmable state (global enable, per-source enable, pending, active, priority), captures rising edges on interrupt sources, and runs a registered priority arbiter. It presents one interrupt request plus a claim/complete handshake through the register map.

## Interface
- NUM_IRQ, 32, number of interrupt sources (1..32)
- PRIO_W, 4, priority field width; priority 0 means "never signal"
- clk  in  1  single clock; all logic on posedge
- rst  in  1  synchronous, active-high reset
- addr  in  8  byte address; addr[1:0] ignored (word access only)
- wr_en  in  1  write strobe, one cycle per write
- rd_en  in  1  read strobe, one cycle per read
- wdata  in  32  write data
- rdata  out  32  read data, registered
- irq_src  in  NUM_IRQ  level sources, synchronous to clk
- irq_out  out  1  interrupt request to the core, registered
- irq_id  out  6  ID+1 of the winning source; 0 = none, registered

Reset is synchronous and active-high on rst, sampled at the posedge of clk. After reset, rdata, irq_out and irq_id are 0. All registers clear, and the irq_src history register clears.

## Operation
- Register map (word offsets):
  - 0x00 CTRL: bit0 = global enable; RW.
  - 0x04 ENABLE: RW.
  - 0x08 PENDING: read returns pending. Write-1-to-clear.
  - 0x0C SETPEND: write-1-to-set pending. Reads 0.
  - 0x10 CLAIM: see below.
  - 0x14 ACTIVE: RO.
  - 0x20–0x2C PRIO0..3: 8 fields of PRIO_W bits per word. Source n is at word n/8, bits [4*(n%8)+:4].
  - 0x3C ID: RO constant 0x4749_4301.
- Unmapped or out-of-range (≥NUM_IRQ) bits: read 0, writes ignored.
- Edge capture: pending[n] sets when irq_src[n]=1 and the previous-cycle sample was 0.
- Pending set/clear priority: a set in the same cycle as a W1C or a claim clear wins (pending stays 1).
- Eligibility: a source is eligible when pending & enable & ~active & prio≠0.
- Arbitration: the winner is the highest priority value; ties go to the lowest index.
- The arbiter result is registered into best_id/best_valid each cycle.
- irq_out is driven as best_valid & CTRL.en.
- Claim: a read of 0x10 returns {26'b0, best_id+1} when best_valid and the result is not stale. In that case, at the same edge, pending[best_id] clears and active[best_id] sets. Otherwise the read returns 0 and changes no state.
- Stale flag: set for one cycle after any register write or successful claim. A claim attempted while the flag is set returns 0.
- Complete (EOI): a write to 0x10 with wdata[5:0]=k, 1≤k≤NUM_IRQ, clears active[k-1]. Other values are ignored.
- Simultaneous wr_en and rd_en: the write takes effect. rdata returns the pre-write value, and a claim side effect is suppressed.
- Reset mid-operation: all state, including active, is lost. A source held high during and after reset does not re-pend, because its history register reloads from the input after reset.

## Timing
- Read latency: 1 cycle. rd_en high at edge E loads rdata at E, so it is valid in cycle E+1 for the initiator's #1 input sample. rdata holds until the next read.
- Write takes effect at the edge where wr_en is sampled high.
- Interrupt path: irq_src first sampled high at edge E → pending at E → irq_out/irq_id at E+1.
- After a claim at E: irq_out re-evaluates at E+1. Claims at E+1 read 0 (stale); claims at E+2 see the new winner.
- No backpressure; every strobe completes in one cycle.

## Structure
- Package gic_reg_pkg holds:
  - address localparams (CTRL_A … ID_A)
  - ID_VALUE
  - the prio_t typedef, logic [PRIO_W-1:0]
- Sub-module gic_prio_arbiter: a combinational max-priority/lowest-index tree over NUM_IRQ eligible bits and priorities. It outputs id and valid; the parent registers them.
- Top level holds the register bank, edge detect, decode, claim/complete logic and the stale flag.

## Test plan
- Reset → rdata=0, irq_out=0, irq_id=0. Read 0x3C after reset → 0x4749_4301.
- Enable src 3 (ENABLE=0x8), PRIO0=0x0000_5000, CTRL=1; pulse irq_src[3] → irq_out=1 one edge after capture; CLAIM read → 4; ACTIVE=0x8; irq_out drops; write 0x10=4 → ACTIVE=0.
- Sources 2 (prio 3) and 5 (prio 7) pending together → CLAIM returns 6. Equal prio 3 on both → CLAIM returns 3.
- Back-to-back CLAIM reads at E and E+1 with two eligible sources → 6 then 0 (stale); a read at E+2 → 3.
- SETPEND 0x1 in the same cycle irq_src[0] rises while a PENDING W1C 0x1 occurs → pending[0]=1. Unmapped read 0x40 → 0.
- Hold irq_src[1]=1, assert rst for 2 cycles mid-claim → all state 0; no new pend after reset until irq_src[1] falls and rises again.
